// File: rtl/soc_wb2bb_pkg.sv
// Shared types and constants for the Wishbone-to-BB bridge.
// Also provides the burst wrap-mask helper.
package soc_wb2bb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RMW_MERGE,
    ST_RMW_WRITE,
    ST_BURST,
    ST_RESP
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  // Address bits that advance during a burst; bits outside the mask stay fixed.
  function automatic logic [31:0] wrap_mask(input logic [1:0] bte, input int sw);
    case (bte)
      BTE_WRAP4:  return 32'(4 * sw - 1);
      BTE_WRAP8:  return 32'(8 * sw - 1);
      BTE_WRAP16: return 32'(16 * sw - 1);
      default:    return '1;
    endcase
  endfunction

endpackage

// File: rtl/soc_wb_burst_addr.sv
// Next-beat address generator for linear and wrapping read bursts.
// Only built when SOC_WB2BB_BURST_EN is defined.
`ifdef SOC_WB2BB_BURST_EN
module soc_wb_burst_addr
  import soc_wb2bb_pkg::*;
#(
  parameter int AW = 16,
  parameter int SW = 4
) (
  input  logic [AW-1:0] cur_addr,
  input  logic [1:0]    bte,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] mask;
  logic [AW-1:0] incr;

  always_comb begin
    mask      = AW'(wrap_mask(bte, SW));
    incr      = cur_addr + AW'(SW);
    next_addr = (cur_addr & ~mask) | (incr & mask);
  end

endmodule
`endif

// File: rtl/soc_wb2bb_bridge.sv
// Wishbone B3 slave to single-port BB SRAM master with byte-select RMW.
// Define SOC_WB2BB_BURST_EN to enable incrementing/wrapping read bursts.
module soc_wb2bb_bridge
  import soc_wb2bb_pkg::*;
#(
  parameter  int AW      = 16,
  parameter  int DW      = 32,
  localparam int SW      = DW / 8,
  localparam int BYTE_AW = SW >> 1
) (
  input  logic          bb_clk_i,
  input  logic          bb_rst_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [SW-1:0] wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [AW-1:0] bb_addr_o,
  output logic [DW-1:0] bb_din_o,
  output logic          bb_en_o,
  output logic          bb_we_o,
  input  logic [DW-1:0] bb_dout_i
);

  localparam logic [AW-1:0] ALIGN_MASK = AW'((1 << BYTE_AW) - 1);

  state_t        state_q, state_d;
  logic          ack_d, err_d;
  logic [DW-1:0] dat_d;
  logic          bb_en, bb_we;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, merge_q, merged;
  logic [SW-1:0] sel_q;
  logic          cyc_lost_q;
  logic          req, bad_req;

  // A still-visible ack/err means the master has not yet retired the last beat.
  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign bad_req = (|(wb_adr_i & ALIGN_MASK)) | (wb_we_i & ~(|wb_sel_i));

`ifdef SOC_WB2BB_BURST_EN
  logic [1:0]    bte_q;
  logic [AW-1:0] next_addr;
  logic          eob;

  assign eob = wb_stb_i & (wb_cti_i == CTI_EOB);

  soc_wb_burst_addr #(.AW(AW), .SW(SW)) u_burst_addr (
    .cur_addr  (addr_q),
    .bte       (bte_q),
    .next_addr (next_addr)
  );
`else
  logic unused_burst;
  assign unused_burst = ^{wb_cti_i, wb_bte_i};
`endif

  always_comb begin
    merged = '0;
    for (int b = 0; b < SW; b++)
      merged[8*b +: 8] = sel_q[b] ? wdata_q[8*b +: 8] : bb_dout_i[8*b +: 8];
  end

  always_comb begin
    // NOTE: every output of this block is assigned a default first so no path infers a latch.
    state_d   = state_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = wb_dat_o;
    bb_en     = 1'b0;
    bb_we     = 1'b0;
    bb_addr_o = addr_q;
    bb_din_o  = merge_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          bb_addr_o = wb_adr_i;
          bb_din_o  = wb_dat_i;
          if (bad_req) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (wb_we_i && (&wb_sel_i)) begin
            bb_en   = 1'b1;
            bb_we   = 1'b1;
            ack_d   = 1'b1;
            state_d = ST_RESP;
          end else if (wb_we_i) begin
            bb_en   = 1'b1;
            state_d = ST_RMW_MERGE;
          end else begin
            bb_en   = 1'b1;
`ifdef SOC_WB2BB_BURST_EN
            state_d = (wb_cti_i == CTI_INCR) ? ST_BURST : ST_READ;
`else
            state_d = ST_READ;
`endif
          end
        end
      end
      ST_READ: begin
        dat_d   = bb_dout_i;
        ack_d   = wb_cyc_i;
        state_d = ST_RESP;
      end
      ST_RMW_MERGE: state_d = ST_RMW_WRITE;
      ST_RMW_WRITE: begin
        // The write always lands so memory never holds a half-merged word.
        bb_en   = 1'b1;
        bb_we   = 1'b1;
        ack_d   = wb_cyc_i & ~cyc_lost_q;
        state_d = ST_RESP;
      end
`ifdef SOC_WB2BB_BURST_EN
      ST_BURST: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (wb_stb_i) begin
          dat_d = bb_dout_i;
          ack_d = 1'b1;
          if (eob) begin
            state_d = ST_IDLE;
          end else begin
            bb_en     = 1'b1;
            bb_addr_o = next_addr;
          end
        end else begin
          bb_en = 1'b1;
        end
      end
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bb_en_o = bb_en & ~bb_rst_i;
  assign bb_we_o = bb_we & ~bb_rst_i;

  always_ff @(posedge bb_clk_i) begin
    if (bb_rst_i) begin
      state_q  <= ST_IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state_q  <= state_d;
      wb_ack_o <= ack_d;
      wb_err_o <= err_d;
      wb_dat_o <= dat_d;
    end
  end

  // NOTE: transfer context is left unreset; it is always reloaded in IDLE before use.
  always_ff @(posedge bb_clk_i) begin
    case (state_q)
      ST_IDLE: begin
        addr_q     <= wb_adr_i;
        wdata_q    <= wb_dat_i;
        sel_q      <= wb_sel_i;
        cyc_lost_q <= 1'b0;
`ifdef SOC_WB2BB_BURST_EN
        bte_q      <= wb_bte_i;
`endif
      end
      ST_RMW_MERGE: begin
        merge_q    <= merged;
        cyc_lost_q <= ~wb_cyc_i;
      end
`ifdef SOC_WB2BB_BURST_EN
      ST_BURST: if (bb_en) addr_q <= bb_addr_o;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_soc_wb2bb_bridge.sv
// Directed self-checking bench for soc_wb2bb_bridge with a 1-cycle-latency SRAM model.
// Burst vectors run only when SOC_WB2BB_BURST_EN is defined.
`timescale 1ns/1ps
module tb_soc_wb2bb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] rdat;
  logic        ack, err;
  logic [15:0] bb_addr;
  logic [31:0] bb_din, bb_dout;
  logic        bb_en, bb_we;

  logic [31:0] mem [256];
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_val;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] exp_addr [8];
  logic [31:0] beat_exp [4];

  always #5 clk = ~clk;

  soc_wb2bb_bridge dut (
    .bb_clk_i  (clk),
    .bb_rst_i  (rst),
    .wb_adr_i  (adr),
    .wb_dat_i  (wdat),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_cti_i  (cti),
    .wb_bte_i  (bte),
    .wb_dat_o  (rdat),
    .wb_ack_o  (ack),
    .wb_err_o  (err),
    .bb_addr_o (bb_addr),
    .bb_din_o  (bb_din),
    .bb_en_o   (bb_en),
    .bb_we_o   (bb_we),
    .bb_dout_i (bb_dout)
  );

  // Single-port SRAM, read data one cycle after the access.
  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (bb_en) begin
      if (bb_we) mem[bb_addr[9:2]] <= bb_din;
      else       bb_dout <= mem[bb_addr[9:2]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    ld_en = 1'b1; ld_idx = idx; ld_val = val;
    tick();
    ld_en = 1'b0;
  endtask

  // One request; records per-cycle BB reads/writes and the cycle offset of ack/err.
  task automatic xfer(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, input logic [2:0] c, input logic [1:0] bt, input int drop_k,
                      output int ack_k, output int err_k, output logic [7:0] rd_m,
                      output logic [7:0] wr_m, output logic [31:0] rd);
    ack_k = -1; err_k = -1; rd_m = '0; wr_m = '0; rd = '0;
    tick();
    adr = a; wdat = d; sel = s; we = w; cti = c; bte = bt; cyc = 1'b1; stb = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == drop_k) begin cyc = 1'b0; stb = 1'b0; end
      #1;
      if (bb_en) begin
        if (bb_we) wr_m[k] = 1'b1;
        else       rd_m[k] = 1'b1;
      end
      if (k > 0 && ack && ack_k < 0) begin ack_k = k; rd = rdat; end
      if (k > 0 && err && err_k < 0) err_k = k;
      if (ack || err) begin cyc = 1'b0; stb = 1'b0; end
      @(posedge clk);
      #1;
    end
    cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
  endtask

  task automatic burst_run(input string name, input logic [7:0] stb_pat, input int eob_k,
                           input logic [7:0] exp_en, input logic [7:0] exp_ack);
    int beat = 0;
    tick();
    adr = 16'h0038; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b01; cyc = 1'b1; stb = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        cyc = (k <= eob_k);
        stb = stb_pat[k] && (k <= eob_k);
        cti = (k == eob_k) ? 3'b111 : 3'b010;
      end
      #1;
      check($sformatf("%s en[%0d]", name, k), 64'(bb_en), 64'(exp_en[k]));
      if (exp_en[k]) check($sformatf("%s addr[%0d]", name, k), 64'(bb_addr), 64'(exp_addr[k]));
      check($sformatf("%s ack[%0d]", name, k), 64'(ack), 64'(exp_ack[k]));
      if (exp_ack[k] && beat < 4) begin
        check($sformatf("%s data[%0d]", name, beat), 64'(rdat), 64'(beat_exp[beat]));
        beat++;
      end
      @(posedge clk);
      #1;
    end
    cyc = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
  endtask

  initial begin
    int          ack_k, err_k, n_acc;
    logic [7:0]  rd_m, wr_m;
    logic [31:0] rd;

    rst = 1'b1; adr = 16'h0010; wdat = '0; sel = 4'hF; we = 1'b0;
    cyc = 1'b1; stb = 1'b1; cti = 3'b000; bte = 2'b00; ld_en = 1'b0; ld_idx = '0; ld_val = '0;

    // Request held during reset must not reach the BB port.
    #1;
    check("reset bb_en", 64'(bb_en), 64'd0);
    check("reset bb_we", 64'(bb_we), 64'd0);
    poke(8'h04, 32'hDEADBEEF);
    poke(8'h08, 32'h0000_0000);
    poke(8'h09, 32'h0BAD_F00D);
    poke(8'h10, 32'h1122_3344);
    poke(8'h14, 32'hA5A5_A5A5);
    poke(8'h18, 32'h0102_0304);
    poke(8'h0C, 32'hC0C0_0030);
    poke(8'h0D, 32'hC0C0_0034);
    poke(8'h0E, 32'hC0C0_0038);
    poke(8'h0F, 32'hC0C0_003C);
    check("reset ack", 64'(ack), 64'd0);
    check("reset err", 64'(err), 64'd0);
    check("reset dat", 64'(rdat), 64'd0);
    check("reset bb_en late", 64'(bb_en), 64'd0);
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    tick();

    // Classic read
    xfer(16'h0010, '0, 4'hF, 1'b0, 3'b000, 2'b00, -1, ack_k, err_k, rd_m, wr_m, rd);
    check("rd ack cycle", 64'(ack_k), 64'd2);
    check("rd data", 64'(rd), 64'hDEADBEEF);
    check("rd bb reads", 64'(rd_m), 64'h01);
    check("rd bb writes", 64'(wr_m), 64'h00);

    // Full write then readback
    xfer(16'h0020, 32'h12345678, 4'hF, 1'b1, 3'b000, 2'b00, -1, ack_k, err_k, rd_m, wr_m, rd);
    check("fw ack cycle", 64'(ack_k), 64'd1);
    check("fw bb writes", 64'(wr_m), 64'h01);
    check("fw bb reads", 64'(rd_m), 64'h00);
    check("fw mem", 64'(mem[8'h08]), 64'h12345678);
    xfer(16'h0020, '0, 4'hF, 1'b0, 3'b000, 2'b00, -1, ack_k, err_k, rd_m, wr_m, rd);
    check("fw readback", 64'(rd), 64'h12345678);

    // Partial write via RMW
    xfer(16'h0040, 32'h0000AB00, 4'b0010, 1'b1, 3'b000, 2'b00, -1, ack_k, err_k, rd_m, wr_m, rd);
    check("pw ack cycle", 64'(ack_k), 64'd3);
    check("pw bb reads", 64'(rd_m), 64'h01);
    check("pw bb writes", 64'(wr_m), 64'h04);
    check("pw mem", 64'(mem[8'h10]), 64'h1122AB44);

    // cyc dropped in RMW_MERGE: write lands, no ack
    xfer(16'h0060, 32'h77000000, 4'b1000, 1'b1, 3'b000, 2'b00, 1, ack_k, err_k, rd_m, wr_m, rd);
    check("cycdrop ack", 64'(ack_k), -64'sd1);
    check("cycdrop bb writes", 64'(wr_m), 64'h04);
    check("cycdrop mem", 64'(mem[8'h18]), 64'h77020304);

    // Errors
    xfer(16'h0021, 32'hFFFFFFFF, 4'hF, 1'b1, 3'b000, 2'b00, -1, ack_k, err_k, rd_m, wr_m, rd);
    check("unal err cycle", 64'(err_k), 64'd1);
    check("unal ack", 64'(ack_k), -64'sd1);
    check("unal bb access", 64'(rd_m | wr_m), 64'h00);
    xfer(16'h0024, 32'hFFFFFFFF, 4'h0, 1'b1, 3'b000, 2'b00, -1, ack_k, err_k, rd_m, wr_m, rd);
    check("sel0 err cycle", 64'(err_k), 64'd1);
    check("sel0 bb access", 64'(rd_m | wr_m), 64'h00);
    check("sel0 mem", 64'(mem[8'h09]), 64'h0BADF00D);

    // Reset while in RMW_MERGE
    tick();
    adr = 16'h0050; wdat = 32'h000000FF; sel = 4'b0001; we = 1'b1; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    #1;
    check("rmwrst read en", 64'(bb_en), 64'd1);
    check("rmwrst read we", 64'(bb_we), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rmwrst bb_en", 64'(bb_en), 64'd0);
    check("rmwrst ack", 64'(ack), 64'd0);
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      if (bb_en) n_acc++;
    end
    check("rmwrst no access", 64'(n_acc), 64'd0);
    check("rmwrst mem", 64'(mem[8'h14]), 64'hA5A5A5A5);

`ifdef SOC_WB2BB_BURST_EN
    beat_exp = '{32'hC0C0_0038, 32'hC0C0_003C, 32'hC0C0_0030, 32'hC0C0_0034};
    exp_addr = '{16'h38, 16'h3C, 16'h30, 16'h34, 16'h0, 16'h0, 16'h0, 16'h0};
    burst_run("wrap4", 8'b0001_1110, 4, 8'b0000_1111, 8'b0011_1100);
    exp_addr = '{16'h38, 16'h3C, 16'h30, 16'h30, 16'h34, 16'h0, 16'h0, 16'h0};
    burst_run("wrap4 gap", 8'b0011_0110, 5, 8'b0001_1111, 8'b0110_1100);
`else
    // Without burst support an incrementing request is a classic read.
    xfer(16'h0038, '0, 4'hF, 1'b0, 3'b010, 2'b01, -1, ack_k, err_k, rd_m, wr_m, rd);
    check("nob ack cycle", 64'(ack_k), 64'd2);
    check("nob data", 64'(rd), 64'hC0C00038);
    check("nob bb reads", 64'(rd_m), 64'h01);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/soc_wb2bb_bridge.md
Name: soc_wb2bb_bridge

Overview:
- Wishbone B3 slave to BB master bridge.
- Sits directly upstream of the single-port BB SRAM wrapper and drives its bb_addr/bb_din/bb_en/bb_we inputs.
- Consumes the SRAM's one-cycle-latency read data.
- Adds Wishbone ack generation, byte-select handling by read-modify-write (the BB port has no byte enables), and an optional incrementing/wrapping read-burst streamer.

Parameters:
- AW, 16, byte address width; must match the downstream SRAM AW.
- DW, 32, data width; valid values 32, 16, 8.
- SW, localparam, DW/8, byte-select width.
- BYTE_AW, localparam, SW>>1, number of byte-in-word address bits.

Ports:
- bb_clk_i  in  1  clock; the only clock.
- bb_rst_i  in  1  reset, synchronous, active-high.
- wb_adr_i  in  AW  byte address.
- wb_dat_i  in  DW  write data.
- wb_sel_i  in  SW  byte selects.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_dat_o  out  DW  read data, registered.
- wb_ack_o  out  1  ack, registered.
- wb_err_o  out  1  error, registered.
- bb_addr_o  out  AW  BB address.
- bb_din_o  out  DW  BB write data.
- bb_en_o  out  1  BB access enable.
- bb_we_o  out  1  BB write enable.
- bb_dout_i  in  DW  BB read data; valid the cycle after a read with bb_en_o=1.

Behaviour:
- Reset (sync, active-high), applied on any cycle including mid-transfer:
  - state->IDLE; wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
  - bb_en_o=0, bb_we_o=0 forced combinationally while bb_rst_i=1.
  - Any in-flight RMW is abandoned; no partial write reaches BB.
- States: IDLE, READ, RMW_MERGE, RMW_WRITE, BURST, RESP.
- BB outputs: bb_en_o/bb_we_o/bb_addr_o/bb_din_o are combinational from state and registered context; bb_en_o=0 in RESP.
- Request: wb_cyc_i & wb_stb_i sampled in IDLE at cycle N.
- Error: address with nonzero low BYTE_AW bits (unaligned), or a write with wb_sel_i==0.
  - No BB access; wb_err_o=1 at N+1 for one cycle -> RESP.
- Classic read:
  - N: bb_en=1, we=0, addr=wb_adr_i -> READ.
  - READ (N+1): wb_dat_o<=bb_dout_i, ack<=1 -> RESP.
  - Ack visible at N+2.
- Full write (all sel bits set):
  - N: bb_en=1, we=1, din=wb_dat_i; ack<=1 -> RESP.
  - Ack visible at N+1.
- Partial write (0 < sel < all ones):
  - N: BB read of the word -> RMW_MERGE.
  - N+1: merge register, per byte = sel ? wb_dat_i : bb_dout_i -> RMW_WRITE.
  - N+2: BB write of the merged word; ack<=1 -> RESP.
  - Ack visible at N+3.
- RESP: ack or err high exactly one cycle; stb ignored -> IDLE. No double issue even if the master holds stb.
- cyc dropped mid-RMW: the write still completes (memory consistency); ack is suppressed.
- bb_addr_o wraps modulo 2^AW.

Optional Feature:
- Macro SOC_WB2BB_BURST_EN.
- Defined, read with wb_cti_i==010:
  - IDLE issues addr A -> BURST.
  - Each BURST cycle with stb=1: wb_dat_o<=bb_dout_i, ack<=1, issue next address.
  - Next address: linear = A+SW; wrapN = upper bits held, low log2(N*SW) bits increment modulo.
  - Steady state: one ack per cycle.
  - stb=0 in BURST: ack<=0; previous address re-issued (pause).
  - cti==111 on an acked beat, or cyc dropped: -> IDLE; prefetched word discarded.
- Undefined: cti/bte ignored; every access is classic. Burst writes are always classic beats.

Decomposition:
- Package soc_wb2bb_pkg: state enum, CTI_CLASSIC/CTI_INCR/CTI_EOB and BTE_* constants, wrap-mask function.
- One sub-module, soc_wb_burst_addr: next-address generator (A, bte, SW) -> next A. Compiled only under SOC_WB2BB_BURST_EN.

Test Plan:
- Classic read, DW=32, mem[0x0010]=0xDEADBEEF:
  - bb_en at N, ack at N+2, wb_dat_o=0xDEADBEEF.
  - Exactly one BB access.
- Full write to 0x0020 with 0x12345678, sel=F:
  - Ack at N+1; readback 0x12345678.
- Partial write sel=0010, data 0x0000AB00 to a word holding 0x11223344:
  - BB read at N, BB write at N+2, ack at N+3.
  - Memory = 0x1122AB44.
- Unaligned address 0x0021:
  - wb_err_o at N+1, no bb_en pulse, ack stays 0.
- Reset asserted in RMW_MERGE:
  - Next cycle bb_en=0, ack=0, state IDLE; word unchanged.
- Burst (macro on), wrap4 from 0x0038:
  - Addresses 38,3C,30,34; four consecutive acks; last beat cti=111.
  - Then IDLE; stb gap mid-burst pauses acks without skipping data.
